// File: rtl/coin_dispenser.sv
// Change-return dispenser: plans a greedy Rs.2/Re.1 split against the coin
// inventories, then fires the eject solenoids one coin at a time.
module coin_dispenser #(
  parameter int AMT_W     = 4,
  parameter int INV_W     = 6,
  parameter int PULSE_CYC = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [AMT_W-1:0] amount,
  input  logic             load,
  input  logic [INV_W-1:0] load_c1,
  input  logic [INV_W-1:0] load_c2,
  output logic             busy,
  output logic             eject1,
  output logic             eject2,
  output logic             done,
  output logic             err,
  output logic [INV_W-1:0] inv_c1,
  output logic [INV_W-1:0] inv_c2
);

  localparam int CW   = AMT_W + 1;
  localparam int WW   = (CW > INV_W) ? CW : INV_W;
  localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {IDLE, PLAN, PULSE, GAP, DONE, ERR} state_t;

  state_t           state, state_nxt;
  logic [AMT_W-1:0] amt_q;
  logic [CW-1:0]    cnt1, cnt2;
  logic [CW-1:0]    coins_left;
  logic [TW-1:0]    tick;
  logic [WW-1:0]    half_w, inv1_w, inv2_w, n2_w, n1_w;
  logic             last_pulse, last_gap, short_c1, nothing_due;

  // Plan is evaluated in a width wide enough for both amount and inventory
  assign half_w      = WW'(amt_q >> 1);
  assign inv1_w      = WW'(inv_c1);
  assign inv2_w      = WW'(inv_c2);
  assign n2_w        = (half_w < inv2_w) ? half_w : inv2_w;
  assign n1_w        = WW'(amt_q) - (n2_w << 1);
  assign short_c1    = (n1_w > inv1_w);
  assign nothing_due = (n1_w == '0) && (n2_w == '0);

  assign coins_left = cnt1 + cnt2;
  assign last_pulse = (state == PULSE) && (tick == TW'(PULSE_CYC - 1));
  assign last_gap   = (state == GAP) && (tick == TW'(GAP_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (req && !load) state_nxt = PLAN;
      PLAN: begin
        if (short_c1)         state_nxt = ERR;
        else if (nothing_due) state_nxt = DONE;
        else                  state_nxt = PULSE;
      end
      PULSE: if (last_pulse) state_nxt = (coins_left == CW'(1)) ? DONE : GAP;
      GAP:   if (last_gap)   state_nxt = PULSE;
      DONE:  state_nxt = IDLE;
      ERR:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Rs.2 coins drain first, so the active coin type is simply cnt2 != 0
  always_ff @(posedge clk) begin
    if (rst) begin
      amt_q  <= '0;
      cnt1   <= '0;
      cnt2   <= '0;
      tick   <= '0;
      inv_c1 <= '0;
      inv_c2 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            inv_c1 <= load_c1;
            inv_c2 <= load_c2;
          end else if (req) begin
            amt_q <= amount;
          end
        end
        PLAN: begin
          cnt2 <= CW'(n2_w);
          cnt1 <= CW'(n1_w);
          tick <= '0;
        end
        PULSE: begin
          if (last_pulse) begin
            tick <= '0;
            if (cnt2 != '0) begin
              cnt2   <= cnt2 - CW'(1);
              inv_c2 <= inv_c2 - INV_W'(1);
            end else begin
              cnt1   <= cnt1 - CW'(1);
              inv_c1 <= inv_c1 - INV_W'(1);
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        GAP: begin
          if (last_gap) tick <= '0;
          else          tick <= tick + TW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign eject2 = (state == PULSE) && (cnt2 != '0);
  assign eject1 = (state == PULSE) && (cnt2 == '0);
  assign done   = (state == DONE);
  assign err    = (state == ERR);

endmodule

// File: tb/tb_coin_dispenser.sv
// Bench for coin_dispenser: directed scenarios then random change requests,
// each cycle compared against a coin-list model of the expected outputs.
module tb_coin_dispenser;

  localparam int AMT_W     = 4;
  localparam int INV_W     = 6;
  localparam int PULSE_CYC = 2;
  localparam int GAP_CYC   = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req;
  logic [AMT_W-1:0] amount;
  logic             load;
  logic [INV_W-1:0] load_c1, load_c2;
  logic             busy, eject1, eject2, done, err;
  logic [INV_W-1:0] inv_c1, inv_c2;

  int vectors    = 0;
  int miscompares = 0;
  int m_inv1     = 0;
  int m_inv2     = 0;

  coin_dispenser #(
    .AMT_W(AMT_W), .INV_W(INV_W), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .amount(amount), .load(load),
    .load_c1(load_c1), .load_c2(load_c2), .busy(busy), .eject1(eject1),
    .eject2(eject2), .done(done), .err(err), .inv_c1(inv_c1), .inv_c2(inv_c2)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] expect_vec(input bit b, input bit e1, input bit e2,
                                             input bit d, input bit e);
    return {b, e1, e2, d, e, INV_W'(m_inv1), INV_W'(m_inv2)};
  endfunction

  task automatic check_output(input string tag, input logic [16:0] exp_v);
    logic [16:0] obs;
    obs = {busy, eject1, eject2, done, err, inv_c1, inv_c2};
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed busy/e1/e2/done/err=%b inv=%0d/%0d, expected %b inv=%0d/%0d",
             tag, obs[16:12], obs[11:6], obs[5:0], exp_v[16:12], exp_v[11:6], exp_v[5:0]);
    end
  endtask

  // Random junk on every input while busy; the DUT must ignore all of it
  task automatic drive_junk();
    req     = 1'($urandom);
    load    = 1'($urandom);
    amount  = AMT_W'($urandom);
    load_c1 = INV_W'($urandom);
    load_c2 = INV_W'($urandom);
  endtask

  task automatic drive_quiet();
    req  = 1'b0;
    load = 1'b0;
  endtask

  task automatic apply_load(input int c1, input int c2, input bit with_req);
    load    = 1'b1;
    load_c1 = INV_W'(c1);
    load_c2 = INV_W'(c2);
    req     = with_req;
    amount  = AMT_W'($urandom);
    @(negedge clk);
    m_inv1 = c1;
    m_inv2 = c2;
    drive_quiet();
    check_output("load", expect_vec(0, 0, 0, 0, 0));
  endtask

  // Expected trace built from the coin list: all Rs.2 coins, then Re.1 coins
  task automatic apply_stimulus(input int amt);
    int n2, n1, coins;
    n2    = (amt / 2 < m_inv2) ? amt / 2 : m_inv2;
    n1    = amt - 2 * n2;
    coins = n1 + n2;
    req    = 1'b1;
    load   = 1'b0;
    amount = AMT_W'(amt);
    @(negedge clk);
    check_output("plan", expect_vec(1, 0, 0, 0, 0));
    drive_junk();
    if (n1 > m_inv1) begin
      @(negedge clk);
      check_output("err", expect_vec(1, 0, 0, 0, 1));
      drive_junk();
    end else begin
      for (int k = 0; k < coins; k++) begin
        for (int p = 0; p < PULSE_CYC; p++) begin
          @(negedge clk);
          check_output(k < n2 ? "pulse2" : "pulse1",
                       expect_vec(1, k >= n2, k < n2, 0, 0));
          drive_junk();
        end
        if (k < n2) m_inv2--;
        else        m_inv1--;
        if (k != coins - 1) begin
          for (int g = 0; g < GAP_CYC; g++) begin
            @(negedge clk);
            check_output("gap", expect_vec(1, 0, 0, 0, 0));
            drive_junk();
          end
        end
      end
      @(negedge clk);
      check_output("done", expect_vec(1, 0, 0, 1, 0));
      drive_junk();
    end
    @(negedge clk);
    drive_quiet();
    check_output("idle", expect_vec(0, 0, 0, 0, 0));
  endtask

  initial begin
    rst = 1'b1;
    drive_quiet();
    amount  = '0;
    load_c1 = '0;
    load_c2 = '0;
    repeat (3) @(negedge clk);
    check_output("reset", expect_vec(0, 0, 0, 0, 0));
    rst = 1'b0;
    @(negedge clk);

    apply_load(3, 2, 1'b0);
    apply_stimulus(7);
    apply_load(0, 3, 1'b0);
    apply_stimulus(3);
    apply_load(5, 0, 1'b0);
    apply_stimulus(4);
    apply_stimulus(0);
    apply_load(4, 4, 1'b1);
    @(negedge clk);
    check_output("load_req_ignored", expect_vec(0, 0, 0, 0, 0));

    // Reset during the second cycle of the first Rs.2 pulse
    apply_load(3, 2, 1'b0);
    req    = 1'b1;
    amount = AMT_W'(7);
    @(negedge clk);
    drive_quiet();
    check_output("rst_plan", expect_vec(1, 0, 0, 0, 0));
    @(negedge clk);
    check_output("rst_pulse_a", expect_vec(1, 0, 1, 0, 0));
    @(negedge clk);
    check_output("rst_pulse_b", expect_vec(1, 0, 1, 0, 0));
    rst  = 1'b1;
    load = 1'b1;
    req  = 1'b1;
    @(negedge clk);
    m_inv1 = 0;
    m_inv2 = 0;
    drive_quiet();
    check_output("rst_mid_op", expect_vec(0, 0, 0, 0, 0));
    rst = 1'b0;
    apply_load(2, 1, 1'b0);
    apply_stimulus(3);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0 || (m_inv1 + m_inv2) < 2)
        apply_load($urandom_range(0, 9), $urandom_range(0, 9), 1'($urandom));
      apply_stimulus($urandom_range(0, 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
